// File: rtl/rgb_to_gray_stream.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_gray_stream
//  Description : Converts a raster-order 24-bit RGB pixel stream into an
//                8-bit grayscale stream using integer luma weights
//                (77*R + 150*G + 29*B + 128) >> 8. The pipeline has three
//                registered stages and a fixed latency of 3 cycles.
//                Output-side raster counters flag the first (sof_o) and
//                last (eof_o) pixel of every frame alongside done_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_to_gray_stream #(
  parameter int IMG_W = 256,  // pixels per line, must be >= 2
  parameter int IMG_H = 256   // lines per frame, must be >= 1
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  input  logic       done_i,       // pixel-valid strobe
  output logic [7:0] grayscale_o,
  output logic       done_o,       // result-valid strobe
  output logic       sof_o,        // first pixel of a frame
  output logic       eof_o         // last pixel of a frame
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // A one-line image still needs a 1-bit row counter to keep widths legal.
  localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
  localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
  localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

  // Luma weights sum to 256, so the rounded result never exceeds 255.
  localparam logic [15:0] c_W_R   = 16'd77;
  localparam logic [15:0] c_W_G   = 16'd150;
  localparam logic [15:0] c_W_B   = 16'd29;
  localparam logic [16:0] c_ROUND = 17'd128;

  // --------------------------------------------------------------------------
  // Stage 1: weighted products
  // --------------------------------------------------------------------------
  logic [15:0] w_prod_r;
  logic [15:0] w_prod_g;
  logic [15:0] w_prod_b;

  logic [15:0] r_s1_prod_r;
  logic [15:0] r_s1_prod_g;
  logic [15:0] r_s1_prod_b;
  logic        r_s1_vld;

  // 8-bit component times 8-bit weight always fits in 16 bits.
  assign w_prod_r = {8'd0, r_i} * c_W_R;
  assign w_prod_g = {8'd0, g_i} * c_W_G;
  assign w_prod_b = {8'd0, b_i} * c_W_B;

  // S1 valid follows done_i every cycle so bubbles travel with the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= done_i;
    end
  end

  // S1 product registers only load on an accepted pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_prod_r <= '0;
      r_s1_prod_g <= '0;
      r_s1_prod_b <= '0;
    end else if (done_i) begin
      r_s1_prod_r <= w_prod_r;
      r_s1_prod_g <= w_prod_g;
      r_s1_prod_b <= w_prod_b;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: rounded sum
  // --------------------------------------------------------------------------
  logic [16:0] w_sum;
  logic [16:0] r_s2_sum;
  logic        r_s2_vld;

  assign w_sum = {1'b0, r_s1_prod_r}
               + {1'b0, r_s1_prod_g}
               + {1'b0, r_s1_prod_b}
               + c_ROUND;

  // S2 valid shifts the S1 valid, carrying bubbles forward unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
    end
  end

  // S2 sum register only loads when S1 holds a real pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_sum <= '0;
    end else if (r_s1_vld) begin
      r_s2_sum <= w_sum;
    end
  end

  // The rounded sum tops out at 65408, so bit 16 is always zero and the low
  // byte is the discarded fraction; only [15:8] reaches the output.
  logic w_sum_unused;
  assign w_sum_unused = ^{r_s2_sum[16], r_s2_sum[7:0]};

  // --------------------------------------------------------------------------
  // Output-side raster position
  // --------------------------------------------------------------------------
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic               w_col_last;
  logic               w_row_last;
  logic               w_at_sof;
  logic               w_at_eof;

  assign w_col_last = (r_col == c_COL_LAST);
  assign w_row_last = (r_row == c_ROW_LAST);
  assign w_at_sof   = (r_col == '0) && (r_row == '0);
  assign w_at_eof   = w_col_last && w_row_last;

  // Counters advance on S2 valid so the position they hold describes the
  // pixel being written into S3 in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_s2_vld) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + c_ROW_ONE;
        end
      end else begin
        r_col <= r_col + c_COL_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: output register
  // --------------------------------------------------------------------------
  // Strobes are rewritten every cycle; frame flags are qualified by valid so
  // they can never appear outside done_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_o <= 1'b0;
      sof_o  <= 1'b0;
      eof_o  <= 1'b0;
    end else begin
      done_o <= r_s2_vld;
      sof_o  <= r_s2_vld & w_at_sof;
      eof_o  <= r_s2_vld & w_at_eof;
    end
  end

  // Grayscale byte holds its last value through bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grayscale_o <= '0;
    end else if (r_s2_vld) begin
      grayscale_o <= r_s2_sum[15:8];
    end
  end

endmodule
`default_nettype wire

// File: doc/rgb_to_gray_stream.md
Name: rgb_to_gray_stream

Overview:
- Upstream neighbour of the Sobel kernel; converts a raster-order 24-bit RGB pixel stream into the 8-bit grayscale stream.
- Output is a single-cycle-per-pixel grayscale byte plus a done strobe, matching the kernel's grayscale_i/done_i inputs.
- Fixed 3-stage pipeline with luma weighting.
- Tracks raster position so it can flag frame start and frame end alongside each output pixel.

Parameters:
- IMG_W, 256, pixels per line (≥2)
- IMG_H, 256, lines per frame (≥1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- r_i  input  8  red component
- g_i  input  8  green component
- b_i  input  8  blue component
- done_i  input  1  pixel-valid strobe; one pixel accepted per cycle it is high
- grayscale_o  output  8  grayscale result
- done_o  output  1  result-valid strobe; connects to kernel done_i
- sof_o  output  1  high with done_o on first pixel of a frame (col 0, row 0)
- eof_o  output  1  high with done_o on last pixel of a frame (col IMG_W-1, row IMG_H-1)

Behaviour:
- Reset (rst=0, asynchronous) clears all pipeline data, valids and counters.
  - grayscale_o=0, done_o=0, sof_o=0, eof_o=0.
  - Column counter=0, row counter=0.
- Arithmetic: gray = (77*R + 150*G + 29*B + 128) >> 8, unsigned.
  - Weights sum to 256, so the maximum is (65280+128)>>8 = 255; no saturation logic.
  - Products are 16 bits wide; the sum is 17 bits wide.
- Pipeline, each stage registered:
  - S1: register the three products and valid.
  - S2: register sum+128 and valid.
  - S3: register bits [15:8] into grayscale_o, valid into done_o.
- Latency is exactly 3 cycles from done_i high to done_o high. Throughput is 1 pixel/cycle. No backpressure.
- Bubbles: done_i low inserts a bubble that propagates unchanged.
  - done_o low for that slot; grayscale_o holds its previous value.
  - Stage data registers load only when their valid input is high.
- Raster counters advance only on output-side pixels (S2 valid, so flags align with S3).
  - col increments per pixel; at IMG_W-1 it wraps to 0 and row increments.
  - At row IMG_H-1 with col IMG_W-1, both wrap to 0 and the next pixel starts a new frame.
- sof_o/eof_o are registered together with done_o and are 0 whenever done_o is 0.
- Simultaneous: IMG_W=1 is not supported (parameter lower bound). With IMG_H=1, eof at col IMG_W-1 of row 0.
- Reset mid-frame:
  - In-flight pixels are discarded and done_o stays 0 while rst=0.
  - The counter restarts, so the first pixel after release carries sof_o.
- No frame-length check on input; pixels beyond a frame simply start the next frame.

Test Plan:
- Reset then single pixels (R,G,B) = (255,255,255)/(0,0,0)/(255,0,0)/(0,255,0)/(0,0,255) with gaps -> grayscale_o = 255/0/77/149/29, each done_o exactly 3 cycles after its done_i, one cycle wide.
- Back-to-back 5 pixels with done_i continuously high -> done_o high for 5 consecutive cycles starting cycle 3, values in input order.
- Stream with done_i pattern 1,0,1,1,0,1 -> identical done_o pattern delayed 3 cycles; grayscale_o unchanged during bubbles.
- IMG_W=4, IMG_H=2, 16 pixels streamed -> sof_o on output pixels 1 and 9, eof_o on output pixels 8 and 16, never outside done_o.
- IMG_W=4, IMG_H=2: reset asserted after 5 pixels with 2 in flight -> outputs 0 immediately (async), no done_o for in-flight pixels. Next pixel after release -> sof_o=1. 8th pixel after release -> eof_o=1.
- Random RGB, 1000 pixels with random done_i -> every grayscale_o equals the reference formula, and the count of done_o equals the count of done_i.
